// File: rtl/count_display_if.sv
// Bundle between the counter stage and the display driver.
//   count, buzzer      : binary count and rollover flag from the counter (async to clk)
//   seg, dig_en        : multiplexed 7-segment drive, polarity set by the driver
//   buzzer_out         : piezo tone drive
//   bcd                : {tens,ones} of the last accepted value, for debug
interface count_display_if;
    logic [6:0] count;
    logic       buzzer;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       buzzer_out;
    logic [7:0] bcd;

    modport master (output count, buzzer, input seg, dig_en, buzzer_out, bcd);
    modport slave  (input count, buzzer, output seg, dig_en, buzzer_out, bcd);
endinterface

// File: rtl/count_display_driver.sv
// Converts the counter's 0-99 binary value to BCD with a subtract-by-10 FSM,
// drives a time-multiplexed two-digit 7-segment display and a buzzer tone.
//   clk     : board clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : count/buzzer in, seg/dig_en/buzzer_out/bcd out (all outputs registered)
module count_display_driver #(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned TONE_DIV      = 25000,
    parameter bit          BLANK_LEADING = 1'b1,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    count_display_if.slave  bus
);

    localparam int unsigned CNT_W  = 7;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]       EN_OFF    = ACTIVE_LOW ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    function automatic logic [SEG_W-1:0] seg7(input logic [DIG_W-1:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Synchronisers; cnt_s3 is the previous synced sample used for the stability test
    logic [CNT_W-1:0] cnt_s1, cnt_s2, cnt_s3;
    logic             buz_s1, buz_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_s1 <= '0;
            cnt_s2 <= '0;
            cnt_s3 <= '0;
            buz_s1 <= 1'b0;
            buz_s2 <= 1'b0;
        end else begin
            cnt_s1 <= bus.count;
            cnt_s2 <= cnt_s1;
            cnt_s3 <= cnt_s2;
            buz_s1 <= bus.buzzer;
            buz_s2 <= buz_s1;
        end
    end

    // Conversion FSM and its datapath
    state_t           state, state_n;
    logic [CNT_W-1:0] work, work_n, acc, acc_n;
    logic [DIG_W-1:0] tens, tens_n, ones, ones_n;
    logic [7:0]       bcd_q, bcd_n;
    logic             ovf, ovf_n;
    logic             stable_new;

    assign stable_new = (cnt_s2 == cnt_s3) && (cnt_s2 != acc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            work  <= '0;
            acc   <= '0;
            tens  <= '0;
            ones  <= '0;
            bcd_q <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            work  <= work_n;
            acc   <= acc_n;
            tens  <= tens_n;
            ones  <= ones_n;
            bcd_q <= bcd_n;
            ovf   <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        work_n  = work;
        acc_n   = acc;
        tens_n  = tens;
        ones_n  = ones;
        bcd_n   = bcd_q;
        ovf_n   = ovf;
        case (state)
            IDLE: begin
                if (stable_new) begin
                    // acc records every accepted value so an out-of-range one is not retried
                    acc_n = cnt_s2;
                    if (cnt_s2 >= 7'd100) begin
                        ovf_n = 1'b1;
                    end else begin
                        work_n  = cnt_s2;
                        tens_n  = '0;
                        state_n = CONV;
                    end
                end
            end
            CONV: begin
                if (work >= 7'd10) begin
                    work_n = work - 7'd10;
                    tens_n = tens + 4'd1;
                end else begin
                    ones_n  = work[DIG_W-1:0];
                    state_n = DONE;
                end
            end
            DONE: begin
                bcd_n   = {tens, ones};
                ovf_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Display multiplex; outputs are computed from next-state so seg and dig_en move together
    logic [REF_W-1:0] refresh_cnt;
    logic             digit_sel, digit_sel_n, disp_on, disp_on_n, ref_wrap;
    logic [SEG_W-1:0] tens_pat, ones_pat, seg_raw, seg_q;
    logic [1:0]       en_raw, dig_en_q;

    always_comb begin
        ref_wrap    = (refresh_cnt == REF_W'(REFRESH_DIV - 1));
        disp_on_n   = disp_on | ref_wrap;
        digit_sel_n = (ref_wrap && disp_on) ? ~digit_sel : digit_sel;
        tens_pat    = seg7(bcd_q[7:4]);
        if (BLANK_LEADING && (bcd_q[7:4] == 4'd0)) tens_pat = SEG_BLANK;
        ones_pat    = seg7(bcd_q[3:0]);
        if (ovf) begin
            tens_pat = SEG_DASH;
            ones_pat = SEG_DASH;
        end
        seg_raw = SEG_BLANK;
        en_raw  = 2'b00;
        if (disp_on_n) begin
            seg_raw = digit_sel_n ? tens_pat : ones_pat;
            en_raw  = digit_sel_n ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
            digit_sel   <= 1'b0;
            disp_on     <= 1'b0;
            seg_q       <= SEG_OFF;
            dig_en_q    <= EN_OFF;
        end else begin
            refresh_cnt <= ref_wrap ? '0 : refresh_cnt + REF_W'(1);
            digit_sel   <= digit_sel_n;
            disp_on     <= disp_on_n;
            seg_q       <= ACTIVE_LOW ? ~seg_raw : seg_raw;
            dig_en_q    <= ACTIVE_LOW ? ~en_raw : en_raw;
        end
    end

    // Buzzer tone; dropping the synced flag clears the counter and silences at once
    logic [TONE_W-1:0] tone_cnt;
    logic              tone_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (!buz_s2) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (tone_cnt == TONE_W'(TONE_DIV - 1)) begin
            tone_cnt <= '0;
            tone_q   <= ~tone_q;
        end else begin
            tone_cnt <= tone_cnt + TONE_W'(1);
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_en     = dig_en_q;
    assign bus.buzzer_out = tone_q;
    assign bus.bcd        = bcd_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver with a short refresh and tone period.
module tb_count_display_driver;

    localparam int unsigned REF  = 8;
    localparam int unsigned TONE = 10;
    localparam logic [1:0]  ONES_EN = 2'b10;
    localparam logic [1:0]  TENS_EN = 2'b01;

    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_checks;

    count_display_if bus ();

    count_display_driver #(
        .REFRESH_DIV   (REF),
        .TONE_DIV      (TONE),
        .BLANK_LEADING (1'b1),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_bcd(input logic [7:0] want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (bus.bcd === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_slot(input logic [1:0] pat, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * REF; i++) begin
            if (bus.dig_en === pat) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        bit ok;
        reset_n    = 1'b0;
        bus.count  = 7'd0;
        bus.buzzer = 1'b0;
        step(3);
        n_checks++; if (bus.bcd !== 8'h00) $display("FAIL reset_bcd got %h want 00", bus.bcd); else n_pass++;
        n_checks++; if (bus.seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", bus.seg); else n_pass++;
        n_checks++; if (bus.dig_en !== 2'b11) $display("FAIL reset_dig_en got %b want 11", bus.dig_en); else n_pass++;
        n_checks++; if (bus.buzzer_out !== 1'b0) $display("FAIL reset_buzzer_out got %b want 0", bus.buzzer_out); else n_pass++;
        reset_n = 1'b1;
        wait_slot(ONES_EN, ok);
        n_checks++; if (!ok || bus.seg !== 7'h40) $display("FAIL first_ones_slot got en=%b seg=%h want en=10 seg=40", bus.dig_en, bus.seg); else n_pass++;
        step(REF);
        n_checks++; if (bus.dig_en !== TENS_EN || bus.seg !== 7'h7F) $display("FAIL tens_blank got en=%b seg=%h want en=01 seg=7f", bus.dig_en, bus.seg); else n_pass++;
        step(REF);
        n_checks++; if (bus.dig_en !== ONES_EN) $display("FAIL slot_alternate got %b want 10", bus.dig_en); else n_pass++;
    endtask

    task automatic test_convert_57();
        bit ok;
        bus.count = 7'd57;
        // 3 sync/stability edges, load, 5 steps, ones, write: update on edge 11
        step(10);
        n_checks++; if (bus.bcd !== 8'h00) $display("FAIL conv57_early got %h want 00", bus.bcd); else n_pass++;
        step(1);
        n_checks++; if (bus.bcd !== 8'h57) $display("FAIL conv57_latency got %h want 57", bus.bcd); else n_pass++;
        step(1);
        wait_slot(TENS_EN, ok);
        n_checks++; if (!ok || bus.seg !== 7'h12) $display("FAIL conv57_tens got seg=%h want 12", bus.seg); else n_pass++;
        wait_slot(ONES_EN, ok);
        n_checks++; if (!ok || bus.seg !== 7'h78) $display("FAIL conv57_ones got seg=%h want 78", bus.seg); else n_pass++;
    endtask

    task automatic test_buzzer_99();
        bit   ok;
        int   tog [3];
        int   n_tog;
        logic prev;
        bus.count = 7'd99;
        wait_bcd(8'h99, 40, ok);
        n_checks++; if (!ok) $display("FAIL conv99 got %h want 99", bus.bcd); else n_pass++;
        bus.buzzer = 1'b1;
        bus.count  = 7'd0;
        n_tog = 0;
        tog   = '{-100, -100, -100};
        prev  = bus.buzzer_out;
        for (int i = 1; i <= 35; i++) begin
            step(1);
            if (bus.buzzer_out !== prev) begin
                if (n_tog < 3) tog[n_tog] = i;
                n_tog++;
                prev = bus.buzzer_out;
            end
        end
        n_checks++; if (n_tog != 3) $display("FAIL tone_toggle_count got %0d want 3", n_tog); else n_pass++;
        n_checks++; if (tog[0] != 12) $display("FAIL tone_first_toggle got %0d want 12", tog[0]); else n_pass++;
        n_checks++; if (tog[1] - tog[0] != 10 || tog[2] - tog[1] != 10) $display("FAIL tone_period got %0d,%0d want 10,10", tog[1] - tog[0], tog[2] - tog[1]); else n_pass++;
        n_checks++; if (bus.buzzer_out !== 1'b1) $display("FAIL tone_level got %b want 1", bus.buzzer_out); else n_pass++;
        n_checks++; if (bus.bcd !== 8'h00) $display("FAIL conv99_to_0 got %h want 00", bus.bcd); else n_pass++;
        bus.buzzer = 1'b0;
        step(3);
        n_checks++; if (bus.buzzer_out !== 1'b0) $display("FAIL tone_stop got %b want 0", bus.buzzer_out); else n_pass++;
    endtask

    task automatic test_overflow();
        bit ok;
        bus.count = 7'd120;
        step(20);
        n_checks++; if (bus.bcd !== 8'h00) $display("FAIL ovf_bcd_hold got %h want 00", bus.bcd); else n_pass++;
        wait_slot(TENS_EN, ok);
        n_checks++; if (!ok || bus.seg !== 7'h3F) $display("FAIL ovf_tens_dash got seg=%h want 3f", bus.seg); else n_pass++;
        wait_slot(ONES_EN, ok);
        n_checks++; if (!ok || bus.seg !== 7'h3F) $display("FAIL ovf_ones_dash got seg=%h want 3f", bus.seg); else n_pass++;
        bus.count = 7'd42;
        wait_bcd(8'h42, 40, ok);
        n_checks++; if (!ok) $display("FAIL conv42 got %h want 42", bus.bcd); else n_pass++;
        step(1);
        wait_slot(TENS_EN, ok);
        n_checks++; if (!ok || bus.seg !== 7'h19) $display("FAIL conv42_tens got seg=%h want 19", bus.seg); else n_pass++;
        wait_slot(ONES_EN, ok);
        n_checks++; if (!ok || bus.seg !== 7'h24) $display("FAIL conv42_ones got seg=%h want 24", bus.seg); else n_pass++;
    endtask

    task automatic test_glitch();
        int unsigned seq [7] = '{43, 106, 11, 75, 58, 90, 73};
        bit bad;
        logic [7:0] seen;
        bad  = 1'b0;
        seen = 8'h42;
        foreach (seq[i]) begin
            bus.count = 7'(seq[i]);
            step(1);
            if (bus.bcd !== 8'h42) begin bad = 1'b1; seen = bus.bcd; end
        end
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (bus.bcd !== 8'h42 && bus.bcd !== 8'h73) begin bad = 1'b1; seen = bus.bcd; end
        end
        n_checks++; if (bad) $display("FAIL glitch_intermediate got %h want only 42 or 73", seen); else n_pass++;
        n_checks++; if (bus.bcd !== 8'h73) $display("FAIL glitch_settle got %h want 73", bus.bcd); else n_pass++;
    endtask

    task automatic test_reset_mid_conv();
        bit ok;
        bus.count = 7'd99;
        step(6);
        reset_n = 1'b0;
        #2;
        n_checks++; if (bus.seg !== 7'h7F || bus.dig_en !== 2'b11) $display("FAIL midreset_display got seg=%h en=%b want 7f 11", bus.seg, bus.dig_en); else n_pass++;
        n_checks++; if (bus.bcd !== 8'h00 || bus.buzzer_out !== 1'b0) $display("FAIL midreset_bcd got %h buz=%b want 00 0", bus.bcd, bus.buzzer_out); else n_pass++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_bcd(8'h99, 40, ok);
        n_checks++; if (!ok) $display("FAIL midreset_reconvert got %h want 99", bus.bcd); else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        test_reset();
        test_convert_57();
        test_buzzer_99();
        test_overflow();
        test_glitch();
        test_reset_mid_conv();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
